decimator: RTL and testbench
============================

DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sample width in bits for input and output.
REQ-002 Parameter DECIM_FACTOR, default 4, decimation ratio; power of two, legal range 2..16.
REQ-003 i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_data  input  DATA_WIDTH  unsigned sample from the upstream average_filter o_data.
REQ-006 i_valid  input  1  i_data is a new sample this cycle; no upstream backpressure, so every valid sample is accepted.
REQ-007 o_data  output  DATA_WIDTH  decimated sample.
REQ-008 o_valid  output  1  o_data holds an unconsumed decimated sample.
REQ-009 i_ready  input  1  downstream accepts o_data; a transfer occurs when o_valid && i_ready.
REQ-010 o_overflow  output  1  an unconsumed output sample was overwritten.

Function
REQ-011 Integrate-and-dump: accumulator width DATA_WIDTH+log2(DECIM_FACTOR), no overflow possible, unsigned arithmetic.
REQ-012 Window counter runs 0..DECIM_FACTOR-1 and advances only on cycles with i_valid high; it wraps to 0 after DECIM_FACTOR-1.
REQ-013 With i_valid high and counter < DECIM_FACTOR-1, accumulator <= accumulator + i_data.
REQ-014 With i_valid high and counter == DECIM_FACTOR-1 (window end): output register <= (accumulator + i_data) >> log2(DECIM_FACTOR), truncated, and accumulator <= 0 in the same edge.
REQ-015 Latency: o_data/o_valid update on the clock edge that samples the last window input; they are visible in the following cycle.
REQ-016 Output FSM states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-017 EMPTY -> FULL on a window end; FULL -> EMPTY on a transfer with no window end in the same cycle; otherwise state holds.
REQ-018 FULL with transfer and window end in the same cycle: new sample loaded, state stays FULL, no overflow.
REQ-019 FULL without transfer and with window end: new sample overwrites o_data (newest kept), state stays FULL, overflow event raised.
REQ-020 o_data is stable while o_valid is high and no window end occurs; o_valid never drops without a transfer.
REQ-021 i_ready is ignored in EMPTY; i_data is ignored when i_valid is low.

Reset
REQ-022 Assertion of i_reset_n low asynchronously clears the accumulator, counter, o_data, o_valid, and o_overflow to 0; the FSM returns to EMPTY.
REQ-023 Reset mid-window discards the partial sum; the first window after reset release starts at counter 0.
REQ-024 Reset release is sampled synchronously; the first accepted sample is the first i_valid edge after release.

Configuration
REQ-025 Macro DECIMATOR_STICKY_OVF_EN defined: o_overflow sets on the first overflow event and holds at 1 until reset.
REQ-026 Macro DECIMATOR_STICKY_OVF_EN undefined: o_overflow is high for exactly one cycle following each overflow event; back-to-back events give back-to-back pulses.

Verification
REQ-027 Reset, DECIM_FACTOR=4, i_ready=1, i_valid=1 with samples 10,20,30,40 -> o_valid high one cycle after the 40 edge with o_data=25, then drops the next cycle.
REQ-028 Gapped input: samples 255,255,255,255 with i_valid low between each -> a single output of 255; the counter does not advance on idle cycles.
REQ-029 i_ready=0, two full windows (1,1,1,1 then 8,8,8,8) -> o_data=1 then 8 and o_overflow asserted (pulse, or sticky if the macro is defined); o_valid stays 1.
REQ-030 Window end coincides with a transfer -> o_data takes the new value, o_valid stays 1, o_overflow stays 0.
REQ-031 Reset asserted asynchronously (mid-cycle) after 2 samples of a window -> all outputs 0 immediately; the next 4 samples 4,4,4,4 produce o_data=4.
REQ-032 DECIM_FACTOR=16, all samples 255 -> accumulator reaches 4080 without wrap and o_data=255.

Source files
------------

// File: rtl/decimator_if.sv
// Stream bundle between the decimator and its neighbours.
//   i_data / i_valid : upstream samples (no backpressure)
//   o_data / o_valid / i_ready : downstream valid/ready handshake
//   o_overflow : unconsumed output sample was overwritten
// Modports: slave = decimator side, master = upstream/downstream side.
interface decimator_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_overflow;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid, o_overflow
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid, o_overflow
  );
endinterface

// File: rtl/decimator.sv
// Integrate-and-dump decimator: averages every DECIM_FACTOR valid samples
// into one output sample held in a one-deep valid/ready output register.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus        : decimator_if.slave (i_data, i_valid, o_data, o_valid,
//                i_ready, o_overflow)
// Parameters: DATA_WIDTH (sample width), DECIM_FACTOR (power of two, 2..16).
// Optional macro DECIMATOR_STICKY_OVF_EN: o_overflow latches on the first
// overwrite until reset; otherwise it pulses one cycle per overwrite.
module decimator #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DECIM_FACTOR = 4
) (
  input logic       i_clk,
  input logic       i_reset_n,
  decimator_if.slave bus
);

  localparam int unsigned SHIFT = $clog2(DECIM_FACTOR);
  localparam int unsigned ACC_W = DATA_WIDTH + SHIFT;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                r_state;
  logic [SHIFT-1:0]      r_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_overflow;

  logic [ACC_W-1:0]      w_sum;
  logic                  w_win_end;
  logic                  w_xfer;
  logic                  w_ovf_evt;

  // Accumulator is wide enough to hold DECIM_FACTOR full-scale samples.
  assign w_sum     = r_acc + ACC_W'(bus.i_data);
  // Counter width is exactly log2(DECIM_FACTOR), so all-ones is the last slot.
  assign w_win_end = bus.i_valid && (r_cnt == '1);
  assign w_xfer    = (r_state == FULL) && bus.i_ready;
  assign w_ovf_evt = w_win_end && (r_state == FULL) && !bus.i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (bus.i_valid) begin
      r_cnt <= r_cnt + SHIFT'(1);
      if (w_win_end) r_acc <= '0;
      else           r_acc <= w_sum;
    end
  end

  // Output FSM; a window end always (re)loads the output register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else begin
      if (w_win_end) r_data <= w_sum[ACC_W-1:SHIFT];
      case (r_state)
        EMPTY:   if (w_win_end) r_state <= FULL;
        FULL:    if (w_xfer && !w_win_end) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else begin
`ifdef DECIMATOR_STICKY_OVF_EN
      if (w_ovf_evt) r_overflow <= 1'b1;
`else
      r_overflow <= w_ovf_evt;
`endif
    end
  end

  assign bus.o_data     = r_data;
  assign bus.o_valid    = (r_state == FULL);
  assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_decimator.sv
module tb_decimator;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  decimator_if #(.DATA_WIDTH(8)) a_if ();
  decimator_if #(.DATA_WIDTH(8)) b_if ();

  decimator #(.DATA_WIDTH(8), .DECIM_FACTOR(4)) u_dut4 (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (a_if.slave)
  );

  decimator #(.DATA_WIDTH(8), .DECIM_FACTOR(16)) u_dut16 (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the DECIM_FACTOR=4 instance
  int         win[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_a(input string tag);
    check({tag, "_valid"}, 32'(a_if.o_valid), 32'(m_valid));
    check({tag, "_data"},  32'(a_if.o_data),  32'(m_data));
    check({tag, "_ovf"},   32'(a_if.o_overflow), 32'(m_ovf));
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input string tag);
    int  sum;
    logic wend, ovf_evt, xfer;
    a_if.i_valid = v;
    a_if.i_data  = d;
    a_if.i_ready = r;
    @(posedge clk);
    xfer = m_valid && r;
    wend = 1'b0;
    sum  = 0;
    if (v) begin
      win.push_back(int'(d));
      if (win.size() == 4) begin
        foreach (win[k]) sum += win[k];
        win.delete();
        wend = 1'b1;
      end
    end
    ovf_evt = wend && m_valid && !r;
    if (wend) begin
      m_data  = 8'(sum / 4);
      m_valid = 1'b1;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
`ifdef DECIMATOR_STICKY_OVF_EN
    m_ovf = m_ovf | ovf_evt;
`else
    m_ovf = ovf_evt;
`endif
    @(negedge clk);
    check_a(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_if.i_valid = 1'b0; a_if.i_data = '0; a_if.i_ready = 1'b0;
    b_if.i_valid = 1'b0; b_if.i_data = '0; b_if.i_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_a("reset");
    check("reset_b_valid", 32'(b_if.o_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sum16;
    logic [7:0] s16[16];
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    do_reset();

    // Basic average 10,20,30,40 -> 25, then drops after transfer
    cycle(1, 10, 1, "b0");
    cycle(1, 20, 1, "b1");
    cycle(1, 30, 1, "b2");
    cycle(1, 40, 1, "b3");
    check("basic_avg", 32'(a_if.o_data), 32'd25);
    check("basic_vld", 32'(a_if.o_valid), 32'd1);
    cycle(0, 0, 1, "b4");
    check("basic_drop", 32'(a_if.o_valid), 32'd0);

    // Gapped input: idle cycles do not advance the counter
    for (int i = 0; i < 4; i++) begin
      cycle(1, 255, 1, "gap_v");
      if (i < 3) check("gap_novalid", 32'(a_if.o_valid), 32'd0);
      cycle(0, 8'($urandom), 1, "gap_idle");
    end
    cycle(0, 0, 1, "gap_tail");

    // Overwrite with no consumer
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, "ovw1");
    check("ovw1_data", 32'(a_if.o_data), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 8, 0, "ovw2");
    check("ovw2_data", 32'(a_if.o_data), 32'd8);
    check("ovw2_ovf",  32'(a_if.o_overflow), 32'd1);
    check("ovw2_vld",  32'(a_if.o_valid), 32'd1);
    cycle(0, 0, 0, "ovw_hold");
    check("ovw_hold_vld", 32'(a_if.o_valid), 32'd1);

    // Window end coincides with transfer
    cycle(1, 3, 0, "co0");
    cycle(1, 3, 0, "co1");
    cycle(1, 3, 0, "co2");
    cycle(1, 5, 1, "co3");
    check("coinc_data", 32'(a_if.o_data), 32'd3);
    check("coinc_vld",  32'(a_if.o_valid), 32'd1);
`ifndef DECIMATOR_STICKY_OVF_EN
    check("coinc_ovf", 32'(a_if.o_overflow), 32'd0);
`endif
    cycle(0, 0, 1, "co_drain");

    // Asynchronous reset mid-window
    cycle(1, 200, 1, "ar0");
    cycle(1, 200, 1, "ar1");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_a("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 4, 0, "post_rst");
    check("post_rst_data", 32'(a_if.o_data), 32'd4);
    cycle(0, 0, 1, "post_rst_drain");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), "rand");

    // DECIM_FACTOR=16: full scale must not wrap
    b_if.i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_if.i_valid = 1'b1;
      b_if.i_data  = 8'd255;
      @(negedge clk);
      if (i < 15) check("d16_novalid", 32'(b_if.o_valid), 32'd0);
    end
    b_if.i_valid = 1'b0;
    check("d16_vld",  32'(b_if.o_valid), 32'd1);
    check("d16_data", 32'(b_if.o_data), 32'd255);
    @(negedge clk);
    check("d16_drop", 32'(b_if.o_valid), 32'd0);
    sum16 = 0;
    for (int i = 0; i < 16; i++) begin
      s16[i] = 8'($urandom);
      sum16 += int'(s16[i]);
    end
    for (int i = 0; i < 16; i++) begin
      b_if.i_valid = 1'b1;
      b_if.i_data  = s16[i];
      @(negedge clk);
    end
    b_if.i_valid = 1'b0;
    check("d16_rand", 32'(b_if.o_data), 32'(sum16 / 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
